// File: rtl/tty_dbg_tx.sv
// Debug-stream UART transmitter: buffers tty_stb bytes in a small FIFO and sends them as 8N1 on txd.
// Two clocks from strobe to start bit; a strobe into a full FIFO is dropped and latches ovf.
module tty_dbg_tx #(
  parameter int REFCLK     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       sys_clk_p,
  input  logic       sys_rst,
  input  logic       tty_stb,
  input  logic [7:0] tty_dat,
  input  logic       tty_end,
  output logic       txd,
  output logic       busy,
  output logic       ovf,
  output logic       done
);

  localparam int DIV   = (REFCLK + BAUD / 2) / BAUD;
  localparam int CW    = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  generate
    if (DIV < 2) begin : g_div_check
      $error("tty_dbg_tx: bit period below 2 clocks");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2:0]   r_wptr;
  logic [DEPTH_LOG2:0]   r_rptr;
  logic [CW-1:0]         r_cnt;
  logic [2:0]            r_bit;
  logic [7:0]            r_shift;
  logic                  r_txd;
  logic                  r_busy;
  logic                  r_ovf;
  logic                  r_end_pend;
  logic                  r_done;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr;
  logic                  w_tick;
  logic                  w_pop;
  logic [CW-1:0]         w_cnt_nxt;
  logic [2:0]            w_bit_nxt;
  logic [7:0]            w_shift_nxt;
  logic                  w_txd_nxt;

  // Extra pointer bit distinguishes full (MSB differs only) from empty (equal).
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = ((r_wptr ^ r_rptr) == {1'b1, {DEPTH_LOG2{1'b0}}});
  assign w_wr    = tty_stb && !w_full;
  assign w_tick  = (r_cnt == CW'(DIV - 1));

  // FSM state register
  always_ff @(posedge sys_clk_p) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = S_START;
      S_START: if (w_tick) w_state_nxt = S_DATA;
      S_DATA:  if (w_tick && (r_bit == 3'd7)) w_state_nxt = S_STOP;
      S_STOP:  if (w_tick) w_state_nxt = w_empty ? S_IDLE : S_START;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: txd is computed for the next state so the pin stays registered.
  always_comb begin
    w_pop       = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick));
    w_cnt_nxt   = ((r_state == S_IDLE) || w_tick) ? '0 : r_cnt + CW'(1);
    w_bit_nxt   = (r_state != S_DATA) ? 3'd0 : (w_tick ? r_bit + 3'd1 : r_bit);
    w_shift_nxt = r_shift;
    if (w_pop)
      w_shift_nxt = r_mem[r_rptr[DEPTH_LOG2-1:0]];
    else if ((r_state == S_DATA) && w_tick)
      w_shift_nxt = {1'b1, r_shift[7:1]};
    case (w_state_nxt)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk_p) begin
    if (w_wr) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= tty_dat;
  end

  always_ff @(posedge sys_clk_p) begin
    if (sys_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_bit      <= 3'd0;
      r_shift    <= 8'h00;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
      r_end_pend <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= !w_empty || (r_state != S_IDLE);
      if (w_wr)             r_wptr     <= r_wptr + 1'b1;
      if (w_pop)            r_rptr     <= r_rptr + 1'b1;
      if (tty_stb && w_full) r_ovf     <= 1'b1;
      if (tty_end)          r_end_pend <= 1'b1;
      if (r_end_pend && w_empty && (r_state == S_IDLE)) r_done <= 1'b1;
    end
  end

  assign txd  = r_txd;
  assign busy = r_busy;
  assign ovf  = r_ovf;
  assign done = r_done;

endmodule

// File: tb/tb_tty_dbg_tx.sv
// Bench for tty_dbg_tx at DIV=10 with a 4-entry FIFO; a UART monitor decodes txd and
// checks each frame against the expected-byte queue filled by the stimulus.
module tb_tty_dbg_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb = 1'b0;
  logic       tend = 1'b0;
  logic [7:0] dat = 8'h00;
  logic       txd, busy, ovf, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [7:0] dat;
    int         start;
  } exp_t;
  exp_t sb[$];

  tty_dbg_tx #(.REFCLK(1000000), .BAUD(100000), .DEPTH_LOG2(2)) dut (
    .sys_clk_p (clk),
    .sys_rst   (rst),
    .tty_stb   (stb),
    .tty_dat   (dat),
    .tty_end   (tend),
    .txd       (txd),
    .busy      (busy),
    .ovf       (ovf),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // UART monitor: samples mid-bit, aborts on reset, pops the scoreboard at each stop bit.
  logic       mon_act = 1'b0;
  logic       mon_frm;
  logic [7:0] mon_dat;
  int         mon_start;
  int         mon_off;
  exp_t       mon_e;

  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (txd === 1'b0) begin
        mon_act   = 1'b1;
        mon_start = cyc;
        mon_frm   = 1'b1;
      end
    end else begin
      mon_off = cyc - mon_start;
      if (mon_off % 10 == 5) begin
        if (mon_off == 5) begin
          mon_frm = mon_frm && (txd === 1'b0);
        end else if (mon_off <= 85) begin
          mon_dat[mon_off / 10 - 1] = txd;
        end else begin
          mon_frm = mon_frm && (txd === 1'b1);
          mon_act = 1'b0;
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame: got byte 0x%02h at cycle %0d, expected no frame", mon_dat, mon_start);
          end else begin
            mon_e = sb.pop_front();
            chk("frame_byte", {24'd0, mon_dat}, {24'd0, mon_e.dat});
            chk("frame_start_cycle", mon_start, mon_e.start);
            chk("frame_start_stop_bits", {31'd0, mon_frm}, 32'd1);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the strobe is sampled at the next rising edge.
  task automatic strobe(input logic [7:0] b, input bit expect_tx, input int start);
    exp_t e;
    stb = 1'b1;
    dat = b;
    if (expect_tx) begin
      e.dat   = b;
      e.start = start;
      sb.push_back(e);
    end
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((busy || sb.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'd0, k < budget}, 32'd1);
    step(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int t0;
    step(3);
    rst = 1'b0;
    chk("reset_txd", {31'd0, txd}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    step(2);

    // Single byte 0x55: start bit two clocks after the strobe edge, busy through the frame.
    t0 = cyc;
    strobe(8'h55, 1'b1, t0 + 2);
    chk("single_txd_before_start", {31'd0, txd}, 32'd1);
    step(1);
    chk("single_start_bit", {31'd0, txd}, 32'd0);
    chk("single_busy", {31'd0, busy}, 32'd1);
    step(100);
    chk("single_busy_last", {31'd0, busy}, 32'd1);
    step(1);
    chk("single_busy_drop", {31'd0, busy}, 32'd0);
    step(3);

    // Back-to-back frames with no idle gap.
    t0 = cyc;
    strobe(8'h41, 1'b1, t0 + 2);
    strobe(8'h42, 1'b1, t0 + 102);
    strobe(8'h43, 1'b1, t0 + 202);
    wait_idle("b2b_drain", 600);

    // End handling: done only after the FSM is back in IDLE, then sticky.
    t0 = cyc;
    strobe(8'h0D, 1'b1, t0 + 2);
    step(2);
    tend = 1'b1;
    step(1);
    tend = 1'b0;
    step(46);
    chk("end_done_mid_frame", {31'd0, done}, 32'd0);
    step(52);
    chk("end_done_at_idle_edge", {31'd0, done}, 32'd0);
    step(1);
    chk("end_done_rise", {31'd0, done}, 32'd1);
    t0 = cyc;
    strobe(8'h7E, 1'b1, t0 + 2);
    chk("end_done_sticky_busy", {31'd0, done}, 32'd1);
    wait_idle("end_drain", 300);
    chk("end_done_sticky_after", {31'd0, done}, 32'd1);

    // Overflow: six strobes into four entries, first byte leaves for the shifter.
    do_reset();
    chk("ovf_reset_done", {31'd0, done}, 32'd0);
    t0 = cyc;
    for (int i = 0; i < 5; i++) strobe(8'(i), 1'b1, t0 + 2 + 100 * i);
    chk("ovf_before_drop", {31'd0, ovf}, 32'd0);
    strobe(8'h05, 1'b0, 0);
    chk("ovf_after_drop", {31'd0, ovf}, 32'd1);
    wait_idle("ovf_drain", 800);

    // Full FIFO plus a STOP pop in the same edge: the write is still refused.
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 5; i++) strobe(8'hA0 + 8'(i), 1'b1, t0 + 2 + 100 * i);
    step(96);
    chk("fullrd_ovf_before", {31'd0, ovf}, 32'd0);
    strobe(8'hFF, 1'b0, 0);
    chk("fullrd_ovf_after", {31'd0, ovf}, 32'd1);
    wait_idle("fullrd_drain", 800);

    // Reset during data bit 4 with two bytes queued: nothing further may be sent.
    t0 = cyc;
    strobe(8'h11, 1'b0, 0);
    strobe(8'h22, 1'b0, 0);
    strobe(8'h33, 1'b0, 0);
    step(54);
    rst = 1'b1;
    step(1);
    chk("midrst_txd", {31'd0, txd}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    step(300);
    chk("midrst_quiet_busy", {31'd0, busy}, 32'd0);
    chk("midrst_quiet_txd", {31'd0, txd}, 32'd1);

    // Simultaneous strobe and end are both honored.
    t0 = cyc;
    tend = 1'b1;
    strobe(8'h5A, 1'b1, t0 + 2);
    tend = 1'b0;
    chk("simul_done_early", {31'd0, done}, 32'd0);
    wait_idle("simul_drain", 300);
    chk("simul_done", {31'd0, done}, 32'd1);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
